// File: rtl/freq_div_ctrl_if.sv
// rtl/freq_div_ctrl_if.sv - configuration handshake and sync bundle for freq_div_ctrl
interface freq_div_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 18
);
    localparam int CH_W = $clog2(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_done;
    logic             sync;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en, sync,
        input  cfg_ready, cfg_done
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en, sync,
        output cfg_ready, cfg_done
    );
endinterface

// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - programmable multi-channel tick / clock-enable generator
module freq_div_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 18,
    parameter int DEFAULT_DIV = 250000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    freq_div_ctrl_if.slave     cfg,
    output logic [NUM_CH-1:0]  o_tick,
    output logic [NUM_CH-1:0]  o_clk_out
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CNT_W-1:0] r_div [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_clk_out;

    logic [0:0]        r_state;
    logic              r_cfg_ready;
    logic              r_cfg_done;
    logic [CH_W-1:0]   r_sh_ch;
    logic [CNT_W-1:0]  r_sh_div;
    logic              r_sh_en;

    logic [NUM_CH-1:0] w_act;
    logic [NUM_CH-1:0] w_term;
    logic              w_apply;

    // Per-channel activity and terminal-count decode from the live settings.
    always_comb begin
        w_act  = '0;
        w_term = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_act[i]  = r_en[i] && (r_div[i] != '0);
            w_term[i] = w_act[i] && (r_cnt[i] == (r_div[i] - CNT_W'(1)));
        end
    end

    // A pending config lands only when its channel is idle, wrapping, or being resynced,
    // so the period in flight always completes with the old divisor.
    always_comb begin
        w_apply = (r_state == S_PEND) &&
                  (cfg.sync || !w_act[r_sh_ch] || w_term[r_sh_ch]);
    end

    // Channel counters, ticks, square waves and live divisor/enable.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= CNT_W'(DEFAULT_DIV);
            end
            r_en      <= '1;
            r_tick    <= '0;
            r_clk_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg.sync) begin
                    r_cnt[i]     <= '0;
                    r_tick[i]    <= 1'b0;
                    r_clk_out[i] <= 1'b0;
                end else if (!w_act[i]) begin
                    r_cnt[i]     <= '0;
                    r_tick[i]    <= 1'b0;
                    r_clk_out[i] <= 1'b0;
                end else if (w_term[i]) begin
                    r_cnt[i]     <= '0;
                    r_tick[i]    <= 1'b1;
                    r_clk_out[i] <= ~r_clk_out[i];
                end else begin
                    r_cnt[i]     <= r_cnt[i] + CNT_W'(1);
                    r_tick[i]    <= 1'b0;
                end
                if (w_apply && (r_sh_ch == CH_W'(i))) begin
                    r_div[i] <= r_sh_div;
                    r_en[i]  <= r_sh_en;
                end
            end
        end
    end

    // Config FSM: accept into the shadow in IDLE, wait in PEND until the apply point.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b1;
            r_cfg_done  <= 1'b0;
            r_sh_ch     <= '0;
            r_sh_div    <= '0;
            r_sh_en     <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg.cfg_valid) begin
                        r_sh_ch     <= cfg.cfg_ch;
                        r_sh_div    <= cfg.cfg_div;
                        r_sh_en     <= cfg.cfg_en;
                        r_state     <= S_PEND;
                        r_cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    if (w_apply) begin
                        r_state     <= S_IDLE;
                        r_cfg_ready <= 1'b1;
                        r_cfg_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign cfg.cfg_done  = r_cfg_done;
    assign o_tick        = r_tick;
    assign o_clk_out     = r_clk_out;
endmodule
